instr_sequencer: RTL

Multi-cycle fetch/decode/branch sequencer that drives the ALU opcode and consumes its BranchFlag. It sits between the synchronous instruction ROM and the ALU/register file. It owns the program counter, issues one ALU operation per instruction, and redirects the PC when a branch op raises BranchFlag. It also handles start/halt handshakes with the top-level test harness.

---
 rtl/instr_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/exec/commit sequencer driving the ALU opcode and program counter
module instr_sequencer #(
    parameter int A  = 10,
    parameter int IW = 9,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [IW-1:0] instr,
    input  logic          branch_flag,
    output logic [A-1:0]  instr_addr,
    output logic [3:0]    alu_op,
    output logic [4:0]    field,
    output logic          reg_wr_en,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] instr_count
);

    // Opcode map: 0..8 write the register file, 9..11 are branches, 12..15 are no-ops.
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_BGE = 4'd9;
    localparam logic [3:0] OP_BNE = 4'd10;
    localparam logic [3:0] OP_BEQ = 4'd11;

    localparam logic [IW-1:0] HALT_WORD = {IW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_COMMIT = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    state_t        state, state_d;
    logic [A-1:0]  pc_q;
    logic [3:0]    opcode_q;
    logic [4:0]    field_q;
    logic          taken_q;
    logic [CW-1:0] count_q;

    logic          is_branch;
    logic          writes_reg;
    logic          launch;
    logic [A-1:0]  offset;

    assign is_branch  = (opcode_q == OP_BGE) || (opcode_q == OP_BNE) || (opcode_q == OP_BEQ);
    assign writes_reg = (opcode_q <= OP_MOV);
    assign launch     = start && ((state == S_IDLE) || (state == S_HALTED));
    assign offset     = {{(A-5){field_q[4]}}, field_q};

    assign instr_addr  = pc_q;
    assign field       = field_q;
    assign instr_count = count_q;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state selection and per-state output decode.
    always_comb begin
        state_d   = state;
        busy      = 1'b0;
        done      = 1'b0;
        alu_op    = 4'd0;
        reg_wr_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                busy    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                busy    = 1'b1;
                state_d = (instr == HALT_WORD) ? S_HALTED : S_EXEC;
            end
            S_EXEC: begin
                busy    = 1'b1;
                alu_op  = opcode_q;
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                busy      = 1'b1;
                alu_op    = opcode_q;
                reg_wr_en = writes_reg;
                state_d   = S_FETCH;
            end
            S_HALTED: begin
                done = 1'b1;
                if (start) state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Program counter, instruction latch, branch decision and retired count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            opcode_q <= '0;
            field_q  <= '0;
            taken_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            if (launch) begin
                pc_q    <= '0;
                count_q <= '0;
            end
            if (state == S_DECODE) begin
                opcode_q <= instr[IW-1:IW-4];
                field_q  <= instr[4:0];
            end
            if (state == S_EXEC) begin
                taken_q <= branch_flag && is_branch;
            end
            if (state == S_COMMIT) begin
                pc_q <= taken_q ? (pc_q + offset) : (pc_q + A'(1));
                if (count_q != {CW{1'b1}}) begin
                    count_q <= count_q + CW'(1);
                end
            end
        end
    end

endmodule
